// File: rtl/wb_bram_pkg.sv
// Shared types and burst address arithmetic for the Wishbone block-RAM target.
package wb_bram_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    localparam int unsigned NEXT_ADR_W = 32;
    localparam logic [NEXT_ADR_W-1:0] NEXT_ADR_ONE = 1;

    // Bits under the mask advance modulo their span; bits above are held, so
    // linear mode wraps the top word back to zero within 'width' bits.
    function automatic logic [NEXT_ADR_W-1:0] next_adr(
        input logic [NEXT_ADR_W-1:0] index,
        input bte_t                  bte,
        input int unsigned           width
    );
        logic [NEXT_ADR_W-1:0] wrap_mask;
        case (bte)
            BTE_WRAP4:  wrap_mask = 32'h0000_0003;
            BTE_WRAP8:  wrap_mask = 32'h0000_0007;
            BTE_WRAP16: wrap_mask = 32'h0000_000F;
            default:    wrap_mask = (width >= NEXT_ADR_W) ? '1
                                    : ((NEXT_ADR_ONE << width) - NEXT_ADR_ONE);
        endcase
        return (index & ~wrap_mask) | ((index + NEXT_ADR_ONE) & wrap_mask);
    endfunction

endpackage

// File: rtl/bram_be_sp.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// read-first output; the output register clears on reset.
module bram_be_sp
    import wb_bram_pkg::*;
#(
    parameter int MEM_ADR_WIDTH = 11,
    parameter int DATA_BYTES    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_ADR_WIDTH-1:0]  adr,
    input  logic [8*DATA_BYTES-1:0]   wdat,
    input  logic [DATA_BYTES-1:0]     wen,
    output logic [8*DATA_BYTES-1:0]   rdat
);

    logic [8*DATA_BYTES-1:0] mem [0:(1<<MEM_ADR_WIDTH)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (wen[i]) begin
                mem[adr][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdat <= '0;
        end else begin
            rdat <= mem[adr];
        end
    end

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM target with registered-feedback bursts: zero-wait
// writes, one wait state on the first read beat, then one read ack per clock.
module wb_bram_burst
    import wb_bram_pkg::*;
#(
    parameter int MEM_ADR_WIDTH = 11,
    parameter int DATA_BYTES    = 4,
    parameter int ADR_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADR_WIDTH-1:0]     adr,
    input  logic [8*DATA_BYTES-1:0]  dat_ms,
    output logic [8*DATA_BYTES-1:0]  dat_sm,
    input  logic [DATA_BYTES-1:0]    sel,
    input  logic                     cyc,
    input  logic                     stb,
    input  logic                     we,
    input  logic [2:0]               cti,
    input  logic [1:0]               bte,
    output logic                     ack,
    output logic                     err
);

    localparam int LANE_BITS = $clog2(DATA_BYTES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [MEM_ADR_WIDTH-1:0]   word_idx;
    logic [MEM_ADR_WIDTH-1:0]   ram_adr;
    logic [DATA_BYTES-1:0]      ram_wen;
    logic [MEM_ADR_WIDTH-1:0]   rd_adr_p1;
    logic                       vld_p1;
    logic                       req;
    logic                       cti_rsvd;
    logic                       burst_end;
    logic                       rd_hit;
    logic                       unused_adr;

    // Only the word-index slice of adr selects storage; the rest is ignored.
    assign unused_adr = ^adr;
    assign word_idx   = adr[MEM_ADR_WIDTH+LANE_BITS-1 : LANE_BITS];

    assign req       = cyc & stb & ~rst;
    assign cti_rsvd  = !(cti == CTI_CLASSIC || cti == CTI_CONST ||
                         cti == CTI_INCR    || cti == CTI_EOB);
    assign burst_end = (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    assign vld_p1    = (state_q != IDLE);
    assign rd_hit    = vld_p1 && (word_idx == rd_adr_p1);

    always_comb begin
        ack     = 1'b0;
        err     = 1'b0;
        ram_adr = word_idx;
        ram_wen = '0;
        state_d = state_q;

        if (req && cti_rsvd) begin
            err = 1'b1;
        end else if (req && we) begin
            ack     = 1'b1;
            ram_wen = sel;
        end else if (req && rd_hit) begin
            ack = 1'b1;
            // Prefetch the following beat so the next clock can ack again.
            if (cti == CTI_INCR) begin
                ram_adr = MEM_ADR_WIDTH'(next_adr(NEXT_ADR_W'(word_idx),
                                                  bte_t'(bte),
                                                  MEM_ADR_WIDTH));
            end
        end

        if (!req || we || cti_rsvd || (ack && burst_end)) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = RD_WAIT;
        end else begin
            state_d = RD_BURST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage p0 -> p1: address presented to the RAM, word appears on dat_sm.
    always_ff @(posedge clk) begin
        rd_adr_p1 <= ram_adr;
    end

    bram_be_sp #(
        .MEM_ADR_WIDTH (MEM_ADR_WIDTH),
        .DATA_BYTES    (DATA_BYTES)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .adr  (ram_adr),
        .wdat (dat_ms),
        .wen  (ram_wen),
        .rdat (dat_sm)
    );

endmodule

// File: tb/tb_wb_bram_burst.sv
// Bench for wb_bram_burst: directed scenarios with fixed expectations plus a
// randomized master checked cycle-by-cycle against a transaction-level model.
module tb_wb_bram_burst;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [31:0] adr, dat_ms, dat_sm;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err;

    int checks   = 0;
    int failures = 0;

    logic        obs_ack, obs_err;
    logic [31:0] obs_dat;
    logic        exp_ack, exp_err;
    logic [31:0] exp_dat;

    logic [31:0] ref_mem [0:2047];
    bit          pf_vld = 1'b0;
    int          pf_idx = 0;

    always #5 clk = ~clk;

    wb_bram_burst #(
        .MEM_ADR_WIDTH (11),
        .DATA_BYTES    (4),
        .ADR_WIDTH     (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .adr    (adr),
        .dat_ms (dat_ms),
        .dat_sm (dat_sm),
        .sel    (sel),
        .cyc    (cyc),
        .stb    (stb),
        .we     (we),
        .cti    (cti),
        .bte    (bte),
        .ack    (ack),
        .err    (err)
    );

    function automatic int nxt(input int i, input logic [1:0] b);
        int n;
        if (b == 2'd0) return (i + 1) % 2048;
        n = 2 << b;
        return i - (i % n) + ((i % n) + 1) % n;
    endfunction

    // Drive one bus cycle, sample at the falling edge, advance the model.
    task automatic bus_cycle(input logic r, input logic c, input logic s, input logic w,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl,
                             input logic [2:0] ct, input logic [1:0] bt);
        int   idx;
        logic rq, rsv;
        rst = r; cyc = c; stb = s; we = w; adr = a; dat_ms = d; sel = sl; cti = ct; bte = bt;
        @(negedge clk);
        obs_ack = ack; obs_err = err; obs_dat = dat_sm;
        idx = int'(a[12:2]);
        rq  = c & s & ~r;
        rsv = !(ct == 3'd0 || ct == 3'd1 || ct == 3'd2 || ct == 3'd7);
        exp_err = rq & rsv;
        exp_ack = rq & ~rsv & (w | (pf_vld && pf_idx == idx));
        exp_dat = ref_mem[idx];
        if (rq && !rsv && w)
            for (int b = 0; b < 4; b++) if (sl[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        if (r || !rq || w || rsv || (exp_ack && (ct == 3'd0 || ct == 3'd7))) begin
            pf_vld = 1'b0;
        end else begin
            pf_vld = 1'b1;
            pf_idx = (exp_ack && ct == 3'd2) ? nxt(idx, bt) : idx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 2'd0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 2'd0);
            checks++;
            if (obs_ack !== 1'b0 || obs_err !== 1'b0 || obs_dat !== 32'h0) begin
                failures++;
                $display("FAIL reset%0d ack=%b err=%b dat=%h required 0 0 00000000", k, obs_ack, obs_err, obs_dat);
            end
        end
    endtask

    task automatic test_write_sel();
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 2'd0);
        checks++;
        if (obs_ack !== 1'b1 || obs_err !== 1'b0) begin
            failures++; $display("FAIL wr_full ack=%b err=%b required ack=1 err=0", obs_ack, obs_err);
        end
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h000000AA, 4'h1, 3'd0, 2'd0);
        checks++;
        if (obs_ack !== 1'b1) begin
            failures++; $display("FAIL wr_lane0 ack=%b required 1", obs_ack);
        end
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'd0, 2'd0);
        checks++;
        if (obs_ack !== 1'b0) begin
            failures++; $display("FAIL classic_wait ack=%b required 0", obs_ack);
        end
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'd0, 2'd0);
        checks++;
        if (obs_ack !== 1'b1 || obs_dat !== 32'hDEADBEAA) begin
            failures++; $display("FAIL classic_data ack=%b dat=%h required ack=1 dat=deadbeaa", obs_ack, obs_dat);
        end
        idle_cycle();
    endtask

    task automatic test_incr_burst();
        logic [31:0] a_t [6];
        logic [2:0]  c_t [6];
        logic        e_t [6];
        logic [31:0] d_t [6];
        for (int i = 0; i < 16; i++) begin
            bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'(i * 4), 32'(i * 32'h11), 4'hF, 3'd0, 2'd0);
            checks++;
            if (obs_ack !== 1'b1) begin
                failures++; $display("FAIL preload%0d ack=%b required 1", i, obs_ack);
            end
        end
        idle_cycle();
        a_t = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        c_t = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd7, 3'd0};
        e_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        d_t = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        for (int k = 0; k < 6; k++) begin
            bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, a_t[k], 32'h0, 4'hF, c_t[k], 2'd0);
            checks++;
            if (obs_ack !== e_t[k] || obs_err !== 1'b0 || (e_t[k] && obs_dat !== d_t[k])) begin
                failures++;
                $display("FAIL incr_beat%0d ack=%b dat=%h required ack=%b dat=%h", k, obs_ack, obs_dat, e_t[k], d_t[k]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_wrap4();
        logic [31:0] a_t [5];
        logic [2:0]  c_t [5];
        logic        e_t [5];
        logic [31:0] d_t [5];
        a_t = '{32'h28, 32'h28, 32'h2C, 32'h20, 32'h24};
        c_t = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd7};
        e_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        d_t = '{32'h0, 32'hAA, 32'hBB, 32'h88, 32'h99};
        for (int k = 0; k < 5; k++) begin
            bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, a_t[k], 32'h0, 4'hF, c_t[k], 2'd1);
            checks++;
            if (obs_ack !== e_t[k] || (e_t[k] && obs_dat !== d_t[k])) begin
                failures++;
                $display("FAIL wrap4_beat%0d ack=%b dat=%h required ack=%b dat=%h", k, obs_ack, obs_dat, e_t[k], d_t[k]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_master_wait();
        logic [31:0] a_t [7];
        logic        s_t [7];
        logic [2:0]  c_t [7];
        logic        e_t [7];
        logic [31:0] d_t [7];
        a_t = '{32'h8, 32'h8, 32'hC, 32'h10, 32'h10, 32'h10, 32'h10};
        s_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        c_t = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd7};
        e_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        d_t = '{32'h0, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h44};
        for (int k = 0; k < 7; k++) begin
            bus_cycle(1'b0, 1'b1, s_t[k], 1'b0, a_t[k], 32'h0, 4'hF, c_t[k], 2'd0);
            checks++;
            if (obs_ack !== e_t[k] || (e_t[k] && obs_dat !== d_t[k])) begin
                failures++;
                $display("FAIL wait_beat%0d ack=%b dat=%h required ack=%b dat=%h", k, obs_ack, obs_dat, e_t[k], d_t[k]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_mismatch_const();
        logic [31:0] a_t [9];
        logic [2:0]  c_t [9];
        logic        e_t [9];
        logic [31:0] d_t [9];
        // Restart at word 6 instead of the prefetched word 2, then a constant burst on word 3.
        a_t = '{32'h4, 32'h4, 32'h18, 32'h18, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC};
        c_t = '{3'd2, 3'd2, 3'd2, 3'd7, 3'd1, 3'd1, 3'd1, 3'd7, 3'd0};
        e_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        d_t = '{32'h0, 32'h11, 32'h0, 32'h66, 32'h0, 32'h33, 32'h33, 32'h33, 32'h0};
        for (int k = 0; k < 9; k++) begin
            bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, a_t[k], 32'h0, 4'hF, c_t[k], 2'd0);
            checks++;
            if (obs_ack !== e_t[k] || (e_t[k] && obs_dat !== d_t[k])) begin
                failures++;
                $display("FAIL mism_const_beat%0d ack=%b dat=%h required ack=%b dat=%h", k, obs_ack, obs_dat, e_t[k], d_t[k]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_err_reset();
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 32'h12345678, 4'hF, 3'd5, 2'd0);
        checks++;
        if (obs_err !== 1'b1 || obs_ack !== 1'b0) begin
            failures++; $display("FAIL err_write err=%b ack=%b required err=1 ack=0", obs_err, obs_ack);
        end
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 3'd5, 2'd0);
        checks++;
        if (obs_err !== 1'b1 || obs_ack !== 1'b0) begin
            failures++; $display("FAIL err_read err=%b ack=%b required err=1 ack=0", obs_err, obs_ack);
        end
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 3'd0, 2'd0);
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 3'd0, 2'd0);
        checks++;
        if (obs_ack !== 1'b1 || obs_err !== 1'b0 || obs_dat !== 32'h55) begin
            failures++; $display("FAIL err_nowrite ack=%b dat=%h required ack=1 dat=00000055", obs_ack, obs_dat);
        end
        idle_cycle();
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'd2, 2'd0);
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'd2, 2'd0);
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 3'd2, 2'd0);
        checks++;
        if (obs_ack !== 1'b1 || obs_dat !== 32'h11) begin
            failures++; $display("FAIL pre_rst_beat ack=%b dat=%h required ack=1 dat=00000011", obs_ack, obs_dat);
        end
        bus_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd2, 2'd0);
        bus_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd2, 2'd0);
        checks++;
        if (obs_ack !== 1'b0 || obs_dat !== 32'h0) begin
            failures++; $display("FAIL rst_abort ack=%b dat=%h required ack=0 dat=00000000", obs_ack, obs_dat);
        end
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd2, 2'd0);
        checks++;
        if (obs_ack !== 1'b0) begin
            failures++; $display("FAIL post_rst_wait ack=%b required 0", obs_ack);
        end
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd7, 2'd0);
        checks++;
        if (obs_ack !== 1'b1 || obs_dat !== 32'h22) begin
            failures++; $display("FAIL post_rst_data ack=%b dat=%h required ack=1 dat=00000022", obs_ack, obs_dat);
        end
        idle_cycle();
    endtask

    task automatic test_top_wrap();
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h1FFC, 32'hCAFE0001, 4'hF, 3'd0, 2'd0);
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h5A5A0000, 4'hF, 3'd0, 2'd0);
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h1FFC, 32'h0, 4'hF, 3'd2, 2'd0);
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h1FFC, 32'h0, 4'hF, 3'd2, 2'd0);
        checks++;
        if (obs_ack !== 1'b1 || obs_dat !== 32'hCAFE0001) begin
            failures++; $display("FAIL top_word ack=%b dat=%h required ack=1 dat=cafe0001", obs_ack, obs_dat);
        end
        bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'd7, 2'd0);
        checks++;
        if (obs_ack !== 1'b1 || obs_dat !== 32'h5A5A0000) begin
            failures++; $display("FAIL top_wrap0 ack=%b dat=%h required ack=1 dat=5a5a0000", obs_ack, obs_dat);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        int          kind, idx, len, n_idle;
        logic        c, s, w, done;
        logic [1:0]  bt;
        logic [2:0]  ct;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin
            bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, 3'd0, 2'd0);
            checks++;
            if (obs_ack !== 1'b1) begin
                failures++; $display("FAIL rnd_preload%0d ack=%b required 1", i, obs_ack);
            end
        end
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 4);
            idx  = $urandom_range(0, 47);
            bt   = 2'($urandom_range(0, 3));
            len  = $urandom_range(1, 6);
            done = 1'b0;
            for (int n = 0; n < 64 && !done; n++) begin
                c = 1'b1; s = 1'b1; w = 1'b0; ct = 3'd0;
                case (kind)
                    0: w = 1'b1;
                    1: ct = 3'd0;
                    2: ct = (len == 1) ? 3'd7 : 3'd2;
                    3: ct = (len == 1) ? 3'd7 : 3'd1;
                    default: begin ct = 3'(3 + $urandom_range(0, 3)); w = 1'($urandom_range(0, 1)); end
                endcase
                if ((kind == 2 || kind == 3) && n > 0 && $urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 0) s = 1'b0; else c = 1'b0;
                end else if (kind == 2 && n > 0 && $urandom_range(0, 9) == 0) begin
                    idx = $urandom_range(0, 47);
                end
                a = ($urandom & 32'hFFFF_E003) | 32'(idx << 2);
                bus_cycle(1'b0, c, s, w, a, $urandom, 4'($urandom_range(0, 15)), ct, bt);
                checks++;
                if (obs_ack !== exp_ack || obs_err !== exp_err || (exp_ack && !w && obs_dat !== exp_dat)) begin
                    failures++;
                    $display("FAIL rnd_t%0d_c%0d ack=%b err=%b dat=%h required ack=%b err=%b dat=%h",
                             t, n, obs_ack, obs_err, obs_dat, exp_ack, exp_err, exp_dat);
                end
                if (kind == 0 || kind == 4) begin
                    done = 1'b1;
                end else if (exp_ack) begin
                    if (kind == 1 || len == 1) done = 1'b1;
                    else begin
                        len--;
                        if (kind == 2) idx = nxt(idx, bt);
                    end
                end
            end
            checks++;
            if (!done) begin
                failures++; $display("FAIL rnd_t%0d_timeout done=0 required 1", t);
            end
            n_idle = $urandom_range(0, 2);
            for (int k = 0; k < n_idle; k++) begin
                bus_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 2'd0);
                checks++;
                if (obs_ack !== 1'b0 || obs_err !== 1'b0) begin
                    failures++; $display("FAIL rnd_idle%0d ack=%b err=%b required 0 0", t, obs_ack, obs_err);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'h0; dat_ms = 32'h0; sel = 4'h0; cti = 3'd0; bte = 2'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_sel();
        test_incr_burst();
        test_wrap4();
        test_master_wait();
        test_mismatch_const();
        test_err_reset();
        test_top_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
